scanline_fill_ctrl: RTL

Parametrised scanline fill sequencer for the 2D raster path. It walks rows y_min..y_max and requests a span [x0,x1] per row from the edge-math unit over a req/ack handshake. It then emits LANES-wide masked pixel-write beats with a fill colour to the frame-buffer writer under valid/ready backpressure. This is the successor to the single-bit fill sequencer: it adds configurable coordinate/colour width, multi-pixel beats, empty-row skipping and backpressure.

---
 rtl/scanline_fill_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/scanline_fill_ctrl.sv
// ---------------------------------------------------------------------------
// scanline_fill_ctrl
//
// Purpose:
//   Scanline fill sequencer for the 2D raster path. It walks rows
//   y_min..y_max. For each row it asks the edge-math unit for the covered
//   span [x0,x1] over a req/ack handshake. It then emits LANES-wide masked
//   pixel-write beats carrying the fill colour to the frame-buffer writer,
//   under valid/ready backpressure. Rows that the shape does not cover
//   produce no beats.
//
// Parameters:
//   COORD_W : width of unsigned x/y coordinates
//   COLOR_W : fill colour width
//   LANES   : pixels per write beat (power of two, 1..16)
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   fill_en                     start pulse, honoured only in IDLE or DONE
//   y_min, y_max, color         fill job, latched on start
//   span_req, span_y            span request for row span_y
//   span_ack                    span response valid
//   span_hit, span_x0, span_x1  span response payload
//   pix_valid, pix_ready        write beat handshake
//   pix_x, pix_y                beat base x (LANES-aligned) and row
//   pix_mask                    bit i enables pixel pix_x+i
//   pix_color                   latched fill colour
//   busy                        high while requesting spans or filling
//   done                        high (level) once the fill has completed
//   fill_abort                  only with FILL_ABORT_EN; forces IDLE
//
// Configuration:
//   `define FILL_ABORT_EN adds the fill_abort input. Without it, a fill
//   always runs to DONE or is stopped by reset.
// ---------------------------------------------------------------------------
module scanline_fill_ctrl #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 24,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_en,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  input  logic [COLOR_W-1:0] color,
  output logic               span_req,
  output logic [COORD_W-1:0] span_y,
  input  logic               span_ack,
  input  logic               span_hit,
  input  logic [COORD_W-1:0] span_x0,
  input  logic [COORD_W-1:0] span_x1,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [LANES-1:0]   pix_mask,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
`ifdef FILL_ABORT_EN
  ,
  input  logic               fill_abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROWREQ = 2'd1,
    S_FILL   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Clears the low bits of an x coordinate so that beats start LANES-aligned.
  localparam logic [COORD_W-1:0] ALIGN_MASK = ~COORD_W'(LANES - 1);
  // Beat stride, widened by one bit so the last-beat test cannot wrap.
  localparam logic [COORD_W:0]   LANES_EXT  = (COORD_W + 1)'(LANES);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] cur_y_q, cur_y_d;
  logic [COORD_W-1:0] y_max_q, y_max_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d;
  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] x1_q, x1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               req_gap_q, req_gap_d;

  logic               abort;
  logic               do_advance;
  logic               beat_last;
  logic               span_empty;
  logic               at_last_row;
  logic [LANES-1:0]   mask_raw;
  logic               in_req;
  logic               in_fill;

`ifdef FILL_ABORT_EN
  assign abort = fill_abort;
`else
  assign abort = 1'b0;
`endif

  // Row-level decisions. The last-beat test runs one bit wider than the
  // coordinates, so a beat that ends at the top of the x range still
  // finishes the row instead of wrapping back to zero.
  assign beat_last   = ({1'b0, cur_x_q} + LANES_EXT) > {1'b0, x1_q};
  assign span_empty  = !span_hit || (span_x0 > span_x1);
  assign at_last_row = (cur_y_q == y_max_q);

  // Per-lane coverage of the current beat against the latched span. Lane
  // positions are also computed one bit wider than the coordinates.
  always_comb begin
    logic [COORD_W:0] lane_x;
    mask_raw = '0;
    lane_x   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x      = {1'b0, cur_x_q} + (COORD_W + 1)'(i);
      mask_raw[i] = (lane_x >= {1'b0, x0_q}) && (lane_x <= {1'b0, x1_q});
    end
  end

  // State and datapath registers. Reset clears everything, so all Moore
  // outputs read zero during and right after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      cur_y_q   <= '0;
      y_max_q   <= '0;
      cur_x_q   <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      color_q   <= '0;
      req_gap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_y_q   <= cur_y_d;
      y_max_q   <= y_max_d;
      cur_x_q   <= cur_x_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      color_q   <= color_d;
      req_gap_q <= req_gap_d;
    end
  end

  // Next-state logic.
  //
  // When a row is skipped, the FSM goes from ROWREQ straight back to ROWREQ
  // for the next row. req_gap_q keeps span_req low for one cycle in that
  // case, so the edge unit always sees a low cycle between two requests.
  // An ack that arrives during the gap cycle is ignored.
  //
  // Row advance is shared by the skip path and the last-beat path. The row
  // compare happens before the increment, so y_max at the top of the range
  // never wraps.
  always_comb begin
    state_d    = state_q;
    cur_y_d    = cur_y_q;
    y_max_d    = y_max_q;
    cur_x_d    = cur_x_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    color_d    = color_q;
    req_gap_d  = req_gap_q;
    do_advance = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort && (state_q == S_DONE)) begin
          state_d = S_IDLE;
        end else if (fill_en) begin
          y_max_d   = y_max;
          color_d   = color;
          req_gap_d = 1'b0;
          if (y_min > y_max) begin
            state_d = S_DONE;
          end else begin
            cur_y_d = y_min;
            state_d = S_ROWREQ;
          end
        end
      end

      S_ROWREQ: begin
        if (abort) begin
          state_d   = S_IDLE;
          req_gap_d = 1'b0;
        end else if (req_gap_q) begin
          req_gap_d = 1'b0;
        end else if (span_ack) begin
          if (span_empty) begin
            do_advance = 1'b1;
            req_gap_d  = 1'b1;
          end else begin
            x0_d    = span_x0;
            x1_d    = span_x1;
            cur_x_d = span_x0 & ALIGN_MASK;
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pix_ready) begin
          if (beat_last) begin
            do_advance = 1'b1;
          end else begin
            cur_x_d = cur_x_q + COORD_W'(LANES);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_advance) begin
      if (at_last_row) begin
        state_d = S_DONE;
      end else begin
        cur_y_d = cur_y_q + COORD_W'(1);
        state_d = S_ROWREQ;
      end
    end
  end

  // Moore outputs. Each output is gated by the state that owns it, so every
  // output reads zero in IDLE and stays stable while a beat is stalled.
  assign in_req    = (state_q == S_ROWREQ);
  assign in_fill   = (state_q == S_FILL);

  assign span_req  = in_req && !req_gap_q;
  assign span_y    = in_req  ? cur_y_q  : '0;
  assign pix_valid = in_fill;
  assign pix_x     = in_fill ? cur_x_q  : '0;
  assign pix_y     = in_fill ? cur_y_q  : '0;
  assign pix_mask  = in_fill ? mask_raw : '0;
  assign pix_color = in_fill ? color_q  : '0;
  assign busy      = in_req || in_fill;
  assign done      = (state_q == S_DONE);

endmodule
